// File: rtl/usr_sequencer.sv
// -----------------------------------------------------------------------------
// usr_sequencer
//
// Command-driven controller for the 4-bit universal shift register (USR).
// It accepts one transmit or receive command at a time over a valid/ready
// handshake. It then drives the USR load / shift_mode / din controls so that:
//   TX : the word is parallel-loaded, then shifted out serially. tx_bit_valid
//        marks the cycles on which the USR serial output carries a data bit.
//   RX : rx_sample strobes WIDTH serial-input samples. The parallel word is
//        then captured from the USR and presented with a one-cycle rx_valid.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   cmd_valid      command offered
//   cmd_ready      sequencer can accept a command (IDLE only)
//   cmd_op         00 TX-left, 01 TX-right, 10 RX-left, 11 RX-right
//   cmd_data       TX word (ignored for RX)
//   usr_load       USR parallel load
//   usr_shift_mode USR shift mode (111 = hold, outputs zero)
//   usr_din        USR parallel data in
//   usr_dout       USR parallel data out
//   tx_bit_valid   USR serial out carries a valid TX bit this cycle
//   rx_sample      USR samples its serial input at the end of this cycle
//   rx_valid       one-cycle pulse, rx_data valid
//   rx_data        captured RX word, held until the next capture
//   busy           sequencer is not IDLE
// -----------------------------------------------------------------------------
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             usr_load,
    output logic [2:0]       usr_shift_mode,
    output logic [WIDTH-1:0] usr_din,
    input  logic [WIDTH-1:0] usr_dout,
    output logic             tx_bit_valid,
    output logic             rx_sample,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       MODE_HOLD = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        TX_LOAD,
        TX_SHIFT,
        RX_SHIFT,
        RX_CAPTURE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic               accept;

    // Translate a command opcode into the USR shift mode that implements it.
    function automatic logic [2:0] map_mode(input logic [1:0] op);
        logic [2:0] mode;
        case (op)
            2'b00:   mode = 3'b011;   // PISO shift left  (MSB out first)
            2'b01:   mode = 3'b100;   // PISO shift right (LSB out first)
            2'b10:   mode = 3'b001;   // SIPO shift left
            default: mode = 3'b010;   // SIPO shift right
        endcase
        return mode;
    endfunction

    // cmd_ready is high exactly in IDLE, so this is the handshake.
    assign accept = (state == IDLE) && cmd_valid;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = cmd_op[1] ? RX_SHIFT : TX_LOAD;
                    cnt_nxt   = '0;
                end
            end
            TX_LOAD: begin
                state_nxt = TX_SHIFT;
                cnt_nxt   = '0;
            end
            TX_SHIFT: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_SHIFT: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = RX_CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RX_CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode: depends on state and latched command only, never on cmd_*.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready      = 1'b0;
        usr_load       = 1'b0;
        usr_shift_mode = MODE_HOLD;
        usr_din        = '0;
        tx_bit_valid   = 1'b0;
        rx_sample      = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            TX_LOAD: begin
                usr_load       = 1'b1;
                usr_din        = data_q;
                usr_shift_mode = map_mode(op_q);
            end
            TX_SHIFT: begin
                usr_shift_mode = map_mode(op_q);
                tx_bit_valid   = 1'b1;
            end
            RX_SHIFT: begin
                usr_shift_mode = map_mode(op_q);
                rx_sample      = 1'b1;
            end
            RX_CAPTURE: begin
                // The mode stays active so usr_dout shows the register. The
                // extra shift this causes at the capture edge is harmless.
                usr_shift_mode = map_mode(op_q);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command latch and RX capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            data_q   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
            rx_valid <= (state == RX_CAPTURE);
            if (state == RX_CAPTURE) begin
                rx_data <= usr_dout;
            end
        end
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_usr_sequencer
//
// Bench for usr_sequencer. It contains a behavioural model of the 4-bit USR
// that the sequencer controls. Stimulus tasks push the expected serial bits
// and RX words into queues. A negedge monitor pops from those queues and
// compares whenever the DUT flags tx_bit_valid or rx_valid.
// -----------------------------------------------------------------------------
module tb_usr_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         usr_load;
    logic [2:0]   usr_shift_mode;
    logic [W-1:0] usr_din;
    logic [W-1:0] usr_dout;
    logic         tx_bit_valid;
    logic         rx_sample;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         busy;

    usr_sequencer #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .usr_load       (usr_load),
        .usr_shift_mode (usr_shift_mode),
        .usr_din        (usr_din),
        .usr_dout       (usr_dout),
        .tx_bit_valid   (tx_bit_valid),
        .rx_sample      (rx_sample),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // ---------------- USR behavioural model ----------------
    logic [W-1:0] usr_q;
    logic         usr_sin = 1'b0;
    logic         usr_sout;

    always @(posedge clk or posedge reset) begin
        if (reset) usr_q <= '0;
        else if (usr_load) usr_q <= usr_din;
        else begin
            case (usr_shift_mode)
                3'b011:  usr_q <= {usr_q[W-2:0], 1'b0};
                3'b100:  usr_q <= {1'b0, usr_q[W-1:1]};
                3'b001:  usr_q <= {usr_q[W-2:0], usr_sin};
                3'b010:  usr_q <= {usr_sin, usr_q[W-1:1]};
                default: usr_q <= usr_q;
            endcase
        end
    end
    assign usr_sout = (usr_shift_mode == 3'b011) ? usr_q[W-1] :
                      (usr_shift_mode == 3'b100) ? usr_q[0] : 1'b0;
    assign usr_dout = (usr_shift_mode == 3'b111) ? '0 : usr_q;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       sout;
        logic [2:0] mode;
    } tx_exp_t;

    tx_exp_t      tx_q[$];
    logic [W-1:0] rx_q[$];
    logic         sin_q[$];
    int           acc_cyc[$];
    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_tx(input logic [1:0] op, input logic [W-1:0] data);
        tx_exp_t e;
        for (int i = 0; i < W; i++) begin
            e.sout = (op == 2'b00) ? data[W-1-i] : data[i];
            e.mode = (op == 2'b00) ? 3'b011 : 3'b100;
            tx_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: consumes expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        tx_exp_t      e;
        logic [W-1:0] r;
        if (!reset) begin
            if (tx_bit_valid) begin
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected: tx_bit_valid=1 with no bit expected (t=%0t)", $time);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_sout", 32'(usr_sout), 32'(e.sout));
                    check("tx_mode", 32'(usr_shift_mode), 32'(e.mode));
                end
            end
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_unexpected: rx_valid=1 rx_data=%0h (t=%0t)", rx_data, $time);
                end else begin
                    r = rx_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(r));
                end
            end
            check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
            if (rx_sample) usr_sin = (sin_q.size() != 0) ? sin_q.pop_front() : 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] op, input logic [W-1:0] data);
        bit ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: cmd_ready never high for op %0d", op);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = ~data;     // later changes must not reach the USR
    endtask

    task automatic wait_idle(input logic [W-1:0] load_data, input bit is_rx,
                             output int busy_cycles, output int load_cycles);
        bit done = 0;
        busy_cycles = 0;
        load_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1; break; end
            busy_cycles++;
            if (usr_load) begin
                load_cycles++;
                check("load_din", 32'(usr_din), 32'(load_data));
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: busy never fell");
        end
        check("rx_valid_after_busy", 32'(rx_valid), 32'(is_rx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load"},   32'(usr_load),       32'(0));
        check({tag, "_mode"},   32'(usr_shift_mode), 32'(3'b111));
        check({tag, "_din"},    32'(usr_din),        32'(0));
        check({tag, "_txbv"},   32'(tx_bit_valid),   32'(0));
        check({tag, "_rxs"},    32'(rx_sample),      32'(0));
        check({tag, "_rxv"},    32'(rx_valid),       32'(0));
        check({tag, "_rxdata"}, 32'(rx_data),        32'(0));
        check({tag, "_busy"},   32'(busy),           32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int bc;
        int lc;
        bit ok;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;

        #12;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'(1));

        // TX-L 1011: sout 1,0,1,1
        push_tx(2'b00, 4'b1011);
        send(2'b00, 4'b1011);
        wait_idle(4'b1011, 1'b0, bc, lc);
        check("txl_busy_cycles", 32'(bc), 32'(5));
        check("txl_load_cycles", 32'(lc), 32'(1));
        check("txl_usr_empty", 32'(usr_q), 32'(0));
        check("txl_dout_zero", 32'(usr_dout), 32'(0));

        // TX-R 1011: sout 1,1,0,1, mode 100 throughout
        push_tx(2'b01, 4'b1011);
        send(2'b01, 4'b1011);
        wait_idle(4'b1011, 1'b0, bc, lc);
        check("txr_busy_cycles", 32'(bc), 32'(5));
        check("txr_load_cycles", 32'(lc), 32'(1));

        // RX-L, sin 1,1,0,1 -> 1101
        sin_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        rx_q.push_back(4'b1101);
        send(2'b10, 4'b0000);
        wait_idle(4'b0000, 1'b1, bc, lc);
        check("rxl_busy_cycles", 32'(bc), 32'(5));
        check("rxl_load_cycles", 32'(lc), 32'(0));

        // RX-R, sin 1,1,0,1 -> 1011, then held for 10 idle cycles
        sin_q = '{1'b1, 1'b1, 1'b0, 1'b1};
        rx_q.push_back(4'b1011);
        send(2'b11, 4'b0000);
        wait_idle(4'b0000, 1'b1, bc, lc);
        check("rxr_busy_cycles", 32'(bc), 32'(5));
        repeat (10) @(negedge clk);
        check("rxr_hold_data", 32'(rx_data), 32'(4'b1011));
        check("rxr_hold_valid", 32'(rx_valid), 32'(0));

        // Reset after two TX bits: only bits 0,1 of 0110 (MSB first) may appear.
        tx_q.push_back('{sout: 1'b0, mode: 3'b011});
        tx_q.push_back('{sout: 1'b1, mode: 3'b011});
        send(2'b00, 4'b0110);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("midrst_bits_seen", 32'(tx_q.size()), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_txbv", 32'(tx_bit_valid), 32'(0));
        end
        push_tx(2'b01, 4'b0110);
        send(2'b01, 4'b0110);
        wait_idle(4'b0110, 1'b0, bc, lc);
        check("postrst_busy_cycles", 32'(bc), 32'(5));

        // Back-to-back: TX-L 0101 then RX-L (sin 0,1,1,1 -> 0111) with
        // cmd_valid held high and cmd_data disturbed while busy.
        acc_cyc.delete();
        push_tx(2'b00, 4'b0101);
        sin_q = '{1'b0, 1'b1, 1'b1, 1'b1};
        rx_q.push_back(4'b0111);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0101;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        cmd_op   = 2'b10;
        cmd_data = 4'b1111;
        for (int i = 0; i < 50 && ok; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(4'b0000, 1'b1, bc, lc);
        check("b2b_rx_busy_cycles", 32'(bc), 32'(5));
        check("b2b_accepts", 32'(acc_cyc.size()), 32'(2));
        if (acc_cyc.size() >= 2)
            check("b2b_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));

        repeat (3) @(negedge clk);
        check("tx_queue_drained", 32'(tx_q.size()), 32'(0));
        check("rx_queue_drained", 32'(rx_q.size()), 32'(0));
        check("sin_queue_drained", 32'(sin_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
